// File: rtl/tbc_pkg.sv
// Shared opcodes and default widths for the 2-bit teaching computer core.
package tbc_pkg;

   localparam int TBC_ADDR_W = 2;
   localparam int TBC_R_W    = 2;

   localparam logic [1:0] OP_INC = 2'b00;
   localparam logic [1:0] OP_JNO = 2'b01;
   localparam logic [1:0] OP_HLT = 2'b10;
   localparam logic [1:0] OP_NOP = 2'b11;

endpackage

// File: rtl/tbc_decode.sv
// Combinational opcode decoder: one-hot inc/jno/hlt, all low for NOP or while reset is asserted.
module tbc_decode
   import tbc_pkg::*;
(
   input  logic       rst_i,
   input  logic [1:0] op_i,
   output logic       inc_o,
   output logic       jno_o,
   output logic       hlt_o
);

   always_comb begin
      inc_o = 1'b0;
      jno_o = 1'b0;
      hlt_o = 1'b0;
      if (!rst_i) begin
         unique case (op_i)
            OP_INC:  inc_o = 1'b1;
            OP_JNO:  jno_o = 1'b1;
            OP_HLT:  hlt_o = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/tbc_core.sv
// Sequential core of the 2-bit teaching computer: PC, R1, RS flag and halt state.
// Defining TBC_RUN_EN adds a run_i stall input; otherwise the core always runs.
module tbc_core
   import tbc_pkg::*;
#(
   parameter int ADDR_W = TBC_ADDR_W,
   parameter int R_W    = TBC_R_W
) (
   input  logic                          CLK,
   input  logic                          Reset,
`ifdef TBC_RUN_EN
   input  logic                          run_i,
`endif
   input  logic [ADDR_W*(2**ADDR_W)-1:0] prog_i,
   output logic [ADDR_W-1:0]             pc_o,
   output logic [ADDR_W-1:0]             instr_o,
   output logic [R_W-1:0]                r1_o,
   output logic                          rs_o,
   output logic                          hlt_o
);

   localparam int NWORDS = 2**ADDR_W;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [R_W-1:0]    r1_q, r1_d;
   logic              rs_q, rs_d;
   logic              hlt_q, hlt_d;

   logic [ADDR_W-1:0] word [NWORDS];
   logic [ADDR_W-1:0] pc_p1, pc_p2, operand;
   logic [R_W-1:0]    r1_sum;
   logic              carry, run, exec;
   logic              dec_inc, dec_jno, dec_hlt;

   for (genvar k = 0; k < NWORDS; k++) begin : g_word
      assign word[k] = prog_i[k*ADDR_W +: ADDR_W];
   end

`ifdef TBC_RUN_EN
   assign run = run_i;
`else
   assign run = 1'b1;
`endif

   assign exec    = run && !hlt_q;
   assign pc_p1   = pc_q + ADDR_W'(1);
   assign pc_p2   = pc_q + ADDR_W'(2);
   assign instr_o = word[pc_q];
   // JNO operand lives in the following word, wrapping past the top of the image
   assign operand = word[pc_p1];
   assign {carry, r1_sum} = {1'b0, r1_q} + (R_W+1)'(1);

   tbc_decode u_decode (
      .rst_i (Reset),
      .op_i  (instr_o[1:0]),
      .inc_o (dec_inc),
      .jno_o (dec_jno),
      .hlt_o (dec_hlt)
   );

   always_comb begin
      pc_d  = pc_q;
      r1_d  = r1_q;
      rs_d  = rs_q;
      hlt_d = hlt_q;
      if (exec) begin
         if (dec_inc) begin
            r1_d = r1_sum;
            rs_d = carry;
            pc_d = pc_p1;
         end else if (dec_jno) begin
            pc_d = rs_q ? pc_p2 : operand;
         end else if (dec_hlt) begin
            hlt_d = 1'b1;
         end else begin
            pc_d = pc_p1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         pc_q  <= '0;
         r1_q  <= '0;
         rs_q  <= 1'b0;
         hlt_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         r1_q  <= r1_d;
         rs_q  <= rs_d;
         hlt_q <= hlt_d;
      end
   end

   assign pc_o  = pc_q;
   assign r1_o  = r1_q;
   assign rs_o  = rs_q;
   assign hlt_o = hlt_q;

endmodule

// File: tb/tb_tbc_core.sv
// Self-checking bench for tbc_core: directed program scenarios plus randomized runs vs. an integer model.
module tb_tbc_core;

   localparam int ADDR_W = 2;
   localparam int R_W    = 2;
   localparam int N      = 1 << ADDR_W;
   localparam int RMOD   = 1 << R_W;
   localparam int PW     = ADDR_W * N;

   logic              CLK = 1'b0;
   logic              Reset;
   logic              run;
   logic [PW-1:0]     prog;
   logic [ADDR_W-1:0] pc_o, instr_o;
   logic [R_W-1:0]    r1_o;
   logic              rs_o, hlt_o;

   int n_tests = 0;
   int n_fail  = 0;
   int m_pc, m_r1, m_rs, m_hlt;

   always #5 CLK = ~CLK;

   tbc_core #(.ADDR_W(ADDR_W), .R_W(R_W)) dut (
      .CLK     (CLK),
      .Reset   (Reset),
`ifdef TBC_RUN_EN
      .run_i   (run),
`endif
      .prog_i  (prog),
      .pc_o    (pc_o),
      .instr_o (instr_o),
      .r1_o    (r1_o),
      .rs_o    (rs_o),
      .hlt_o   (hlt_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int word(input int k);
      logic [PW-1:0] p;
      p = prog >> (k * ADDR_W);
      return int'(p) % N;
   endfunction

   // Reference behaviour, applied with the inputs that the coming edge will see
   task automatic model_step();
      int op;
      if (Reset) begin
         m_pc = 0; m_r1 = 0; m_rs = 0; m_hlt = 0;
      end else if (run && m_hlt == 0) begin
         op = word(m_pc) % 4;
         case (op)
            0: begin
               m_rs = (m_r1 == RMOD - 1) ? 1 : 0;
               m_r1 = (m_r1 + 1) % RMOD;
               m_pc = (m_pc + 1) % N;
            end
            1: m_pc = (m_rs != 0) ? (m_pc + 2) % N : word((m_pc + 1) % N);
            2: m_hlt = 1;
            default: m_pc = (m_pc + 1) % N;
         endcase
      end
   endtask

   task automatic tick(input string tag);
      model_step();
      @(posedge CLK);
      #1;
      chk({tag, ".pc"},    32'(pc_o),    m_pc);
      chk({tag, ".r1"},    32'(r1_o),    m_r1);
      chk({tag, ".rs"},    32'(rs_o),    m_rs);
      chk({tag, ".hlt"},   32'(hlt_o),   m_hlt);
      chk({tag, ".instr"}, 32'(instr_o), word(m_pc));
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      tick("rst");
      Reset = 1'b0;
   endtask

   localparam logic [PW-1:0] PROG_A   = {2'b10, 2'b00, 2'b01, 2'b00};
   localparam logic [PW-1:0] PROG_JNO = {2'b01, 2'b11, 2'b11, 2'b10};
   int exp_pc [9] = '{1, 0, 1, 0, 1, 0, 1, 3, 3};

   initial begin
      Reset = 1'b1;
      run   = 1'b1;
      prog  = PROG_A;

      // reset state
      tick("init");
      chk("rst_pc", 32'(pc_o), 0);
      chk("rst_r1", 32'(r1_o), 0);
      chk("rst_hlt", 32'(hlt_o), 0);
      Reset = 1'b0;

      // INC/JNO loop until overflow, then skip to HLT
      for (int i = 0; i < 12; i++) begin
         tick("progA");
         if (i < 9) chk("progA_seq", 32'(pc_o), exp_pc[i]);
         if (i == 6) chk("progA_rs", 32'(rs_o), 1);
         if (i == 7) chk("progA_nohlt", 32'(hlt_o), 0);
         if (i >= 8) chk("progA_hlt", 32'(hlt_o), 1);
      end

      // reset mid-run with R1 = 2
      do_reset();
      for (int i = 0; i < 3; i++) tick("mid");
      chk("mid_r1", 32'(r1_o), 2);
      do_reset();
      chk("mid_rst_pc", 32'(pc_o), 0);
      chk("mid_rst_r1", 32'(r1_o), 0);
      tick("mid_restart");
      chk("mid_restart_r1", 32'(r1_o), 1);

      // halted core ignores program changes
      for (int i = 0; i < 10; i++) tick("tohalt");
      chk("tohalt_hlt", 32'(hlt_o), 1);
      prog = '0;
      for (int i = 0; i < 10; i++) tick("frozen");
      chk("frozen_pc", 32'(pc_o), 3);
      chk("frozen_r1", 32'(r1_o), 0);
      do_reset();
      tick("resume");
      chk("resume_r1", 32'(r1_o), 1);

      // all NOP: PC wraps, R1 untouched
      prog = '1;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         tick("nop");
         chk("nop_pc", 32'(pc_o), (i + 1) % N);
      end
      chk("nop_r1", 32'(r1_o), 0);

      // JNO at top of image, operand fetched from word 0
      do_reset();
      for (int i = 0; i < 3; i++) tick("jno0_pre");
      prog = PROG_JNO;
      tick("jno0");
      chk("jno_rs0_pc", 32'(pc_o), 2);
      prog = '0;
      do_reset();
      for (int i = 0; i < 4; i++) tick("jno1_inc");
      chk("jno1_rs", 32'(rs_o), 1);
      prog = '1;
      for (int i = 0; i < 3; i++) tick("jno1_nop");
      prog = PROG_JNO;
      tick("jno1");
      chk("jno_rs1_pc", 32'(pc_o), 1);

`ifdef TBC_RUN_EN
      // stall mid-program, then continue from the same PC
      prog = PROG_A;
      do_reset();
      for (int i = 0; i < 3; i++) tick("run_pre");
      run = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick("stall");
         chk("stall_pc", 32'(pc_o), 1);
         chk("stall_r1", 32'(r1_o), 2);
      end
      run = 1'b1;
      tick("run_post");
      chk("run_post_pc", 32'(pc_o), 0);
`endif

      // randomized programs with sporadic reset, stalls and image changes
      for (int t = 0; t < 25; t++) begin
         prog = PW'($urandom);
         do_reset();
         for (int c = 0; c < 30; c++) begin
            Reset = ($urandom_range(19) == 0);
            if ($urandom_range(7) == 0) prog = PW'($urandom);
`ifdef TBC_RUN_EN
            run = ($urandom_range(3) != 0);
`else
            run = 1'b1;
`endif
            tick("rand");
         end
         Reset = 1'b0;
         run   = 1'b1;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tbc_core.md
Name: tbc_core

Overview:
- Sequential core of the 2-bit teaching computer.
- Holds the program counter (PC), the incrementing register R1, the status flag RS and the halt state.
- Fetches instruction words from an externally supplied, combinationally read program image and executes one instruction per clock.
- Program storage lives outside the block and arrives as a flat input bus.

Parameters:
- ADDR_W, 2: PC width and instruction word width. Program holds 2**ADDR_W words. Minimum 2.
- R_W, 2: width of R1.

Ports:
- CLK  in  1  clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- prog_i  in  ADDR_W*2**ADDR_W  program image; word k = prog_i[k*ADDR_W +: ADDR_W].
- pc_o  out  ADDR_W  current PC (address of the word being executed).
- instr_o  out  ADDR_W  word at pc_o (combinational fetch).
- r1_o  out  R_W  R1 contents.
- rs_o  out  1  status flag (overflow of last INC).
- hlt_o  out  1  high while halted.

Behaviour:
- Opcode = word[1:0]; upper word bits ignored for decode.
  - 00 INC
  - 01 JNO
  - 10 HLT
  - 11 NOP
- Reset (sync, highest priority, overrides halt): pc=0, R1=0, RS=0, hlt=0. Cycle after Reset deasserts executes word 0.
- INC: R1 <= R1+1 mod 2**R_W; RS <= carry-out (1 only on wrap all-ones→0, else 0); pc <= pc+1.
- JNO: two-word instruction; operand = word at pc+1 (mod 2**ADDR_W), used as full ADDR_W-bit target.
  - RS==0: pc <= operand.
  - RS==1: pc <= pc+2 (operand skipped).
  - R1 and RS unchanged.
  - Single cycle.
- HLT: hlt <= 1; pc, R1, RS frozen. While hlt=1 no instruction executes and prog_i changes have no effect on state. Leaving halt requires Reset.
- NOP: pc <= pc+1 only.
- PC arithmetic wraps modulo 2**ADDR_W (pc=max INC → 0; JNO at max reads operand at word 0).
- Outputs are direct register values; instr_o is combinational from pc_o and prog_i.
- Latency: state change visible one cycle after the edge that executes the instruction.

Optional Feature:
- Macro: TBC_RUN_EN.
- Defined: adds input run_i (1 bit). When run_i=0 the core stalls: no state update, Reset still effective. When run_i=1, normal execution.
- Undefined: port absent; core always runs.

Decomposition:
- Package tbc_pkg: opcode localparams (OP_INC, OP_JNO, OP_HLT, OP_NOP) and default widths.
- One sub-module, tbc_decode: combinational opcode decoder producing one-hot inc/jno/hlt, forced all-low during Reset.
- Registers stay in tbc_core.

Test Plan:
- Program {INC, JNO, 00, HLT} (words 0..3 = 00, 01, 00, 10), ADDR_W=R_W=2, Reset one cycle:
  - pc sequence 0,1,0,1,0,1,0,1,3, then held at 3.
  - R1 1,2,3,0.
  - RS=1 after fourth INC.
  - hlt_o=1 from cycle 9 onward.
- Same program, Reset pulsed mid-run while R1=2: next cycle pc=0, R1=0, RS=0, hlt=0, then the sequence restarts.
- After halt, change prog_i to all-INC: pc, R1, RS unchanged for 10 cycles. Reset resumes execution.
- Program all NOP: pc counts 0,1,2,3,0 (wrap); R1 stays 0.
- JNO at word 3 with word 0 = 10, RS=0: pc jumps to 2. With RS=1: pc = 3+2 = 1 (mod 4).
- TBC_RUN_EN defined, run_i=0 for 3 cycles mid-program: no state change. run_i=1 continues from the same pc.
